// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes
// and the datapath mux-select codes the control FSM drives.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multi-cycle MIPS core; outputs decode from state (plus mem_ready/opcode).
// Fetch and memory states hold until mem_ready, stretching the instruction by one cycle per wait.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int OPC_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    output logic               IRwrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               IorD,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSrc,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_e r_state;
    state_e w_next_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state_dbg = r_state;

    always_comb begin
        w_next_state = S_FETCH;
        IRwrite      = 1'b0;
        PCWrite      = 1'b0;
        Branch       = 1'b0;
        IorD         = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        ALUOp        = ALUOP_ADD;
        PCSrc        = PCSRC_ALURES;
        illegal_op   = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcB = SRCB_FOUR;
                IRwrite = mem_ready;
                PCWrite = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SL2;
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
                illegal_op = !is_known_op(opcode);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                if (opcode == OP_LW) begin
                    w_next_state = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next_state = S_MEMWR;
                end
            end
            S_MEMRD: begin
                IorD = 1'b1;
                w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        // Reset kills every write strobe in the same cycle so an aborted op leaves no side effect.
        if (!rst_n) begin
            IRwrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; control outputs are packed into one
// 16-bit word and compared against hand-derived per-state constants.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IRwrite, PCWrite, Branch, IorD, MemWrite, RegWrite;
    logic       RegDst, MemtoReg, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // {IRwrite,PCWrite,Branch,IorD,MemWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSrc,illegal_op}
    logic [15:0] ctl;
    assign ctl = {IRwrite, PCWrite, Branch, IorD, MemWrite, RegWrite, RegDst,
                  MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op};

    localparam logic [15:0] C_FETCH_RDY  = 16'hC020;
    localparam logic [15:0] C_FETCH_WAIT = 16'h0020;
    localparam logic [15:0] C_DECODE     = 16'h0060;
    localparam logic [15:0] C_DECODE_ILL = 16'h0061;
    localparam logic [15:0] C_MEMADR     = 16'h00C0;
    localparam logic [15:0] C_MEMRD      = 16'h1000;
    localparam logic [15:0] C_MEMWB      = 16'h0500;
    localparam logic [15:0] C_MEMWR      = 16'h1800;
    localparam logic [15:0] C_EXECUTE    = 16'h0090;
    localparam logic [15:0] C_ALUWB      = 16'h0600;
    localparam logic [15:0] C_BRANCH     = 16'h208A;
    localparam logic [15:0] C_ADDIEX     = 16'h00C0;
    localparam logic [15:0] C_ADDIWB     = 16'h0400;
    localparam logic [15:0] C_JUMP       = 16'h4004;
    localparam logic [15:0] C_MEMWR_RST  = 16'h1000;

    multicycle_control_fsm #(.STATE_W(4), .OPC_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .IRwrite    (IRwrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Settle combinational outputs, compare state and control word, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] exp_st, input logic [15:0] exp_ctl);
        #1;
        checks++;
        assert (state_dbg === exp_st) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", tag, state_dbg, exp_st);
        end
        checks++;
        assert (ctl === exp_ctl) else begin
            errors++;
            $error("FAIL %s ctl: got %h expected %h", tag, ctl, exp_ctl);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b100011;
        @(posedge clk);
        #1;

        // Reset held with mem_ready high: state FETCH, enables suppressed.
        cyc("rst0", 4'd0, C_FETCH_WAIT);
        cyc("rst1", 4'd0, C_FETCH_WAIT);
        rst_n = 1'b1;

        // lw with no waits: 0,1,2,3,4 then back to 0.
        cyc("lw_fetch",  4'd0, C_FETCH_RDY);
        cyc("lw_decode", 4'd1, C_DECODE);
        cyc("lw_memadr", 4'd2, C_MEMADR);
        cyc("lw_memrd",  4'd3, C_MEMRD);
        cyc("lw_memwb",  4'd4, C_MEMWB);

        // sw with two wait cycles in MEMWR.
        opcode = 6'b101011;
        cyc("sw_fetch",  4'd0, C_FETCH_RDY);
        cyc("sw_decode", 4'd1, C_DECODE);
        cyc("sw_memadr", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        cyc("sw_wr_w0",  4'd5, C_MEMWR);
        cyc("sw_wr_w1",  4'd5, C_MEMWR);
        mem_ready = 1'b1;
        cyc("sw_wr_rdy", 4'd5, C_MEMWR);

        // Fetch stall for four cycles, then beq.
        opcode    = 6'b000100;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("fetch_stall", 4'd0, C_FETCH_WAIT);
        mem_ready = 1'b1;
        cyc("beq_fetch",  4'd0, C_FETCH_RDY);
        cyc("beq_decode", 4'd1, C_DECODE);
        cyc("beq_branch", 4'd8, C_BRANCH);

        // j
        opcode = 6'b000010;
        cyc("j_fetch",  4'd0, C_FETCH_RDY);
        cyc("j_decode", 4'd1, C_DECODE);
        cyc("j_jump",   4'd11, C_JUMP);

        // R-type
        opcode = 6'b000000;
        cyc("r_fetch",   4'd0, C_FETCH_RDY);
        cyc("r_decode",  4'd1, C_DECODE);
        cyc("r_execute", 4'd6, C_EXECUTE);
        cyc("r_aluwb",   4'd7, C_ALUWB);

        // addi
        opcode = 6'b001000;
        cyc("addi_fetch",  4'd0, C_FETCH_RDY);
        cyc("addi_decode", 4'd1, C_DECODE);
        cyc("addi_ex",     4'd9, C_ADDIEX);
        cyc("addi_wb",     4'd10, C_ADDIWB);

        // lw with one wait in MEMRD.
        opcode = 6'b100011;
        cyc("lw2_fetch",  4'd0, C_FETCH_RDY);
        cyc("lw2_decode", 4'd1, C_DECODE);
        cyc("lw2_memadr", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        cyc("lw2_rd_w0",  4'd3, C_MEMRD);
        mem_ready = 1'b1;
        cyc("lw2_rd_rdy", 4'd3, C_MEMRD);
        cyc("lw2_memwb",  4'd4, C_MEMWB);

        // Illegal opcode: pulse in DECODE, then straight back to FETCH.
        opcode = 6'b111111;
        cyc("ill_fetch",  4'd0, C_FETCH_RDY);
        cyc("ill_decode", 4'd1, C_DECODE_ILL);
        cyc("ill_after",  4'd0, C_FETCH_RDY);

        // Reset during MEMWR: MemWrite drops immediately, FETCH after the edge.
        opcode = 6'b101011;
        cyc("mr_decode", 4'd1, C_DECODE);
        cyc("mr_memadr", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        cyc("mr_memwr",  4'd5, C_MEMWR);
        rst_n = 1'b0;
        cyc("mr_rst_in_wr", 4'd5, C_MEMWR_RST);
        mem_ready = 1'b1;
        cyc("mr_rst_fetch", 4'd0, C_FETCH_WAIT);
        rst_n = 1'b1;
        cyc("mr_release", 4'd0, C_FETCH_RDY);
        cyc("mr_decode2", 4'd1, C_DECODE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
